// File: rtl/video_tx_pkg.sv
// video_tx_pkg: shared state encoding and timing helpers for the video stream transmitter
package video_tx_pkg;

    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

    // Total length of a line or frame: active + front porch + sync + back porch
    function automatic int span_total(int act, int fp, int sw, int bp);
        return act + fp + sw + bp;
    endfunction

    // Counter width able to hold 0..n-1
    function automatic int cw(int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tx_sync_fifo.sv
// tx_sync_fifo: single-clock pixel FIFO with occupancy count, overflow/underflow-safe push/pop
import video_tx_pkg::*;

module tx_sync_fifo #(
    parameter int AW = 4,
    parameter int W  = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic [AW:0]  count,
    output logic         full,
    output logic         empty
);

    logic [W-1:0]  mem [2**AW];
    logic [AW-1:0] wptr, rptr;
    logic          do_push, do_pop;

    assign full    = count[AW];
    assign empty   = count == '0;
    assign do_push = push & !full;
    assign do_pop  = pop & !empty;
    assign rdata   = mem[rptr];

    // Data array needs no reset; only pointers and occupancy define validity
    always_ff @(posedge clk)
        if (do_push) mem[wptr] <= wdata;

    // Pointer and occupancy update; push and pop together leave count unchanged
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= wptr + AW'(do_push);
            rptr  <= rptr + AW'(do_pop);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end

endmodule

// File: rtl/video_stream_tx.sv
// video_stream_tx: FIFO-buffered pixel transmitter with regenerated raster timing; VIDEO_TX_PATTERN_EN adds a test pattern source
import video_tx_pkg::*;

module video_stream_tx #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SW        = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SW        = 2,
    parameter int V_BP        = 33,
    parameter bit SYNC_ACTIVE = 1'b1,
    parameter int FIFO_AW     = 4,
    parameter int FILL_THR    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
`ifdef VIDEO_TX_PATTERN_EN
    input  logic       pattern_sel,
`endif
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    output logic       o_H_SYNC,
    output logic       o_V_SYNC,
    output logic       o_data_en,
    output logic [7:0] o_data,
    output logic       o_TVALID,
    output logic       o_frame_start,
    output logic       underflow
);

    localparam int H_TOTAL = span_total(H_ACTIVE, H_FP, H_SW, H_BP);
    localparam int V_TOTAL = span_total(V_ACTIVE, V_FP, V_SW, V_BP);
    localparam int HW = cw(H_TOTAL);
    localparam int VW = cw(V_TOTAL);
    localparam logic [HW-1:0] H_A  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_S0 = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_S1 = HW'(H_ACTIVE + H_FP + H_SW - 1);
    localparam logic [HW-1:0] H_E  = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_A  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_S0 = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_S1 = VW'(V_ACTIVE + V_FP + V_SW - 1);
    localparam logic [VW-1:0] V_E  = VW'(V_TOTAL - 1);
    localparam logic [FIFO_AW:0] THR = (FIFO_AW+1)'(FILL_THR);

    state_t            state;
    logic [HW-1:0]     h_cnt;
    logic [VW-1:0]     v_cnt;
    logic [FIFO_AW:0]  count;
    logic [7:0]        head, pat_px;
    logic              full, empty, run, act, pop, h_end, v_end, frame0, sel, pat;

`ifdef VIDEO_TX_PATTERN_EN
    assign sel    = pattern_sel;
    assign pat_px = 8'(h_cnt) ^ 8'(v_cnt);
`else
    assign sel    = 1'b0;
    assign pat_px = 8'd0;
`endif

    assign run    = state == RUN;
    assign act    = run & (h_cnt < H_A) & (v_cnt < V_A);
    assign pop    = act & !pat;
    assign h_end  = h_cnt == H_E;
    assign v_end  = v_cnt == V_E;
    assign frame0 = run & (h_cnt == '0) & (v_cnt == '0);
    assign s_ready = !full;

    tx_sync_fifo #(.AW(FIFO_AW), .W(8)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (s_valid),
        .pop   (pop),
        .wdata (s_data),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // Frame sequencing and raster counters; en and pattern_sel only act at frame boundaries
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            pat   <= 1'b0;
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (en) begin
                    state <= sel ? RUN : FILL;
                    pat   <= sel;
                end
                FILL: if (count >= THR || full) state <= RUN;
                RUN: begin
                    h_cnt <= h_end ? '0 : h_cnt + 1'b1;
                    if (h_end) v_cnt <= v_end ? '0 : v_cnt + 1'b1;
                    if (h_end && v_end) begin
                        pat   <= sel;
                        state <= !en ? IDLE : (!sel && count < THR) ? FILL : RUN;
                    end
                end
                default: state <= IDLE;
            endcase
        end

    // Output stage: one register delay from counter state; an empty FIFO keeps timing but blanks data
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            o_H_SYNC      <= !SYNC_ACTIVE;
            o_V_SYNC      <= !SYNC_ACTIVE;
            o_data_en     <= 1'b0;
            o_data        <= 8'd0;
            o_TVALID      <= 1'b0;
            o_frame_start <= 1'b0;
            underflow     <= 1'b0;
        end else begin
            o_H_SYNC      <= (run && h_cnt >= H_S0 && h_cnt <= H_S1) ? SYNC_ACTIVE : !SYNC_ACTIVE;
            o_V_SYNC      <= (run && v_cnt >= V_S0 && v_cnt <= V_S1) ? SYNC_ACTIVE : !SYNC_ACTIVE;
            o_data_en     <= act;
            o_data        <= !act ? 8'd0 : pat ? pat_px : empty ? 8'd0 : head;
            o_TVALID      <= run;
            o_frame_start <= frame0;
            underflow     <= (frame0 ? 1'b0 : underflow) | (act & empty & !pat);
        end

endmodule

// File: tb/tb_video_stream_tx.sv
// tb_video_stream_tx: randomized scoreboard bench for video_stream_tx against a queue/position reference model
module tb_video_stream_tx;

    localparam int HT = 16, VT = 8, HA = 8, VA = 4, FRAME = HT * VT;

    typedef struct packed {
        logic       rdy, hs, vs, de;
        logic [7:0] d;
        logic       tv, fs, uf;
    } vec_t;

    logic       clk = 0, rst_n = 0, en = 0, s_valid = 0, s_ready;
    logic [7:0] s_data = 0, o_data;
    logic       o_H_SYNC, o_V_SYNC, o_data_en, o_TVALID, o_frame_start, underflow;

    int checks = 0, errors = 0;
    int sent = 0, src_pct = 100;
    bit src_on = 0;

    vec_t       exp_q[$];
    logic [7:0] mq[$];
    int         mode = 0, pos = 0;
    bit         muf = 0;

    video_stream_tx #(
        .H_ACTIVE(8), .H_FP(2), .H_SW(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SW(2), .V_BP(1),
        .SYNC_ACTIVE(1'b1), .FIFO_AW(4), .FILL_THR(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .o_H_SYNC(o_H_SYNC), .o_V_SYNC(o_V_SYNC), .o_data_en(o_data_en), .o_data(o_data),
        .o_TVALID(o_TVALID), .o_frame_start(o_frame_start), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // Source: sequential pixel values, random valid density, changes away from the active edge
    initial forever begin
        @(negedge clk);
        #1;
        s_valid = src_on && ($urandom_range(99) < src_pct);
        s_data  = 8'(sent);
    end

    always @(posedge clk) if (rst_n && s_valid && s_ready) sent++;

    // Reference model: frame position index plus a queue standing in for the FIFO
    always @(posedge clk) begin
        vec_t e;
        int h, v, sz;
        bit a;
        e = '0;
        if (!rst_n) begin
            mq.delete();
            mode = 0;
            pos  = 0;
            muf  = 0;
        end else begin
            sz = mq.size();
            h  = pos % HT;
            v  = pos / HT;
            if (mode == 2) begin
                a    = h < HA && v < VA;
                e.tv = 1;
                e.de = a;
                e.hs = h >= 10 && h < 13;
                e.vs = v >= 5 && v < 7;
                e.fs = pos == 0;
                if (pos == 0) muf = 0;
                if (a && sz == 0) muf = 1;
                if (a && sz > 0) e.d = mq.pop_front();
            end
            if (s_valid && sz < 16) mq.push_back(s_data);
            if (mode == 0) begin
                if (en) mode = 1;
            end else if (mode == 1) begin
                if (sz >= 8) mode = 2;
            end else if (pos == FRAME - 1) begin
                pos = 0;
                if (!en) mode = 0;
                else if (sz < 8) mode = 1;
            end else pos++;
        end
        e.uf  = muf;
        e.rdy = mq.size() < 16;
        exp_q.push_back(e);
    end

    // Monitor: every output cycle is compared against the oldest expected record
    always @(negedge clk) begin
        vec_t e, g;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = {s_ready, o_H_SYNC, o_V_SYNC, o_data_en, o_data, o_TVALID, o_frame_start, underflow};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL outputs @%0t: got rdy=%b hs=%b vs=%b de=%b d=%02h tv=%b fs=%b uf=%b, expected rdy=%b hs=%b vs=%b de=%b d=%02h tv=%b fs=%b uf=%b",
                         $time, g.rdy, g.hs, g.vs, g.de, g.d, g.tv, g.fs, g.uf,
                         e.rdy, e.hs, e.vs, e.de, e.d, e.tv, e.fs, e.uf);
            end
        end
    end

    task automatic check(string name, int got, int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic step(int n);
        repeat (n) begin
            @(negedge clk);
            #2;
        end
    endtask

    task automatic wait_fs(int limit, output int n);
        n = 0;
        do begin
            step(1);
            n++;
        end while (!o_frame_start && n < limit);
        check("frame_start_seen", o_frame_start, 1);
    endtask

    initial begin
        int n, m;
        step(3);
        rst_n  = 1;
        src_on = 1;
        step(30);
        check("idle_fifo_full_sready", s_ready, 0);
        check("idle_tvalid", o_TVALID, 0);
        check("idle_data_en", o_data_en, 0);

        en = 1;
        wait_fs(100, n);
        check("first_pixel", o_data, 0);
        wait_fs(400, n);
        check("frame_period", n, FRAME);
        check("second_frame_pixel", o_data, 32);
        n = 0;
        while (!o_V_SYNC && n < 200) begin step(1); n++; end
        check("vsync_offset", n, 80);
        m = 0;
        while (o_V_SYNC && m < 100) begin step(1); m++; end
        check("vsync_width", m, 32);

        src_on = 0;
        n = 0;
        while (!underflow && n < 400) begin step(1); n++; end
        check("underflow_set", underflow, 1);
        check("underflow_data_blank", o_data, 0);
        src_on  = 1;
        src_pct = 70;
        wait_fs(1000, n);
        check("underflow_cleared", underflow, 0);

        wait_fs(1000, n);
        step(40);
        en = 0;
        n = 40;
        while (o_TVALID && n < 300) begin step(1); n++; end
        check("en_drop_frame_len", n, FRAME);
        step(60);
        check("after_drop_data_en", o_data_en, 0);
        check("after_drop_tvalid", o_TVALID, 0);

        src_pct = 100;
        en = 1;
        wait_fs(1000, n);
        step(21);
        check("pre_reset_data_en", o_data_en, 1);
        rst_n = 0;
        #1;
        check("reset_outputs", {s_ready, o_H_SYNC, o_V_SYNC, o_data_en, o_data, o_TVALID, o_frame_start, underflow},
              15'h4000);
        step(2);
        rst_n = 1;
        n = 0;
        while (!o_TVALID && n < 100) begin step(1); n++; end
        check("restart_fill_latency", n, 10);
        step(300);
        src_on = 0;
        step(5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
